// File: rtl/io_irq_timer_pkg.sv
// Shared definitions for the io_irq_timer bus responder: register map
// offsets, CTRL bit positions, timer FSM state codes and write decode.
package io_irq_timer_pkg;

    // Default placement of the 8-word register window.
    localparam logic [15:0] DEFAULT_BASE = 16'hFF00;

    // Interrupt source layout: source 0 is the timer, 1..7 are external lines.
    localparam int unsigned NUM_EXT = 7;
    localparam int unsigned NUM_SRC = 8;

    // Word offsets inside the window.
    typedef logic [2:0] reg_off_t;

    localparam reg_off_t OFF_CTRL   = 3'd0;
    localparam reg_off_t OFF_PERIOD = 3'd1;
    localparam reg_off_t OFF_COUNT  = 3'd2;
    localparam reg_off_t OFF_MASK   = 3'd3;
    localparam reg_off_t OFF_PEND   = 3'd4;

    // CTRL register bit positions.
    localparam int unsigned CTRL_EN_BIT     = 0;
    localparam int unsigned CTRL_RELOAD_BIT = 1;

    // Reset values of the programmable registers.
    localparam logic [15:0] PERIOD_RESET = 16'hFFFF;
    localparam logic [7:0]  MASK_RESET   = 8'h00;

    // Timer FSM state codes (one bit is enough: stopped or counting).
    localparam logic [0:0] TMR_IDLE = 1'b0;
    localparam logic [0:0] TMR_RUN  = 1'b1;

    // One strobe per writable register, valid for the current bus cycle.
    typedef struct packed {
        logic ctrl;
        logic period;
        logic count;
        logic mask;
        logic pend;
    } wr_strobe_t;

    // Turn a qualified write cycle and its offset into per-register strobes.
    // Offsets 5..7 produce no strobe, so writes there are silently dropped.
    function automatic wr_strobe_t decode_write(input logic wr_en, input reg_off_t off);
        wr_strobe_t s;
        s        = '0;
        s.ctrl   = wr_en && (off == OFF_CTRL);
        s.period = wr_en && (off == OFF_PERIOD);
        s.count  = wr_en && (off == OFF_COUNT);
        s.mask   = wr_en && (off == OFF_MASK);
        s.pend   = wr_en && (off == OFF_PEND);
        return s;
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchroniser followed by a rising-edge detector, one lane per
// input bit. A rise on irq_async_i shows up on rise_o for exactly one cycle,
// two clock edges after the line was first sampled high.
module irq_sync_edge #(
    parameter int unsigned W = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] irq_async_i,
    output logic [W-1:0] rise_o
);

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_lane
            logic meta_q;
            logic sync_q;
            logic prev_q;

            // Resynchronise the line and keep the previous synchronised value.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    meta_q <= 1'b0;
                    sync_q <= 1'b0;
                    prev_q <= 1'b0;
                end else begin
                    meta_q <= irq_async_i[gi];
                    sync_q <= meta_q;
                    prev_q <= sync_q;
                end
            end

            assign rise_o[gi] = sync_q & ~prev_q;
        end
    endgenerate

endmodule

// File: rtl/io_irq_timer.sv
// Memory-mapped interrupt/timer block on the CPU data bus. Decodes an 8-word
// window at BASE, answers reads combinationally on the shared data bus and
// captures writes on the next rising edge. Holds a prescaled down-counter
// (interrupt source 0) and seven synchronised external edge sources (1..7);
// pending bits are sticky until cleared by a write-1-to-clear to PEND, and
// int_e is the AND of pending and mask flops.
module io_irq_timer
    import io_irq_timer_pkg::*;
#(
    parameter logic [15:0] BASE     = DEFAULT_BASE,
    parameter int unsigned PRESCALE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addresses,
    input  logic        oe,
    inout  wire  [15:0] data,
    input  logic [6:0]  ext_irq,
    output logic [7:0]  int_e
);

    // Last prescaler value before a timer step; PRESCALE=1 steps every cycle.
    localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);

    // Bus decode. BASE[2:0] is ignored: the window is always 8-word aligned.
    logic        sel;
    reg_off_t    off;
    logic        wr_en;
    logic        rd_en;
    wr_strobe_t  wr;
    logic [15:0] wdata;
    logic [15:0] rdata;

    // Architectural state.
    logic [0:0]  tmr_state_q, tmr_state_d;
    logic        reload_q,    reload_d;
    logic [15:0] period_q,    period_d;
    logic [15:0] count_q,     count_d;
    logic [15:0] presc_q,     presc_d;
    logic [7:0]  mask_q,      mask_d;
    logic [7:0]  pend_q,      pend_d;

    // Timer events for the current cycle.
    logic        running;
    logic        step;
    logic        at_end;
    logic        expire;

    // Synchronised external edges.
    logic [NUM_EXT-1:0] ext_rise;

    assign sel   = (addresses[15:3] == BASE[15:3]);
    assign off   = addresses[2:0];
    assign wr_en = sel & oe;
    // Reset is folded in so the bus is released the moment reset falls,
    // not at the next clock edge.
    assign rd_en = sel & ~oe & reset;
    assign wr    = decode_write(wr_en, off);
    assign wdata = data;

    // Drive the bus only during a selected read; otherwise float it.
    assign data = rd_en ? rdata : 16'hzzzz;

    // Level interrupt outputs straight from flops, so no decode glitches.
    assign int_e = pend_q & mask_q;

    irq_sync_edge #(
        .W (NUM_EXT)
    ) u_sync_edge (
        .clk         (clk),
        .rst_n       (reset),
        .irq_async_i (ext_irq),
        .rise_o      (ext_rise)
    );

    // Read mux for the register window; unmapped offsets read as zero.
    always_comb begin
        rdata = '0;
        case (off)
            OFF_CTRL: begin
                rdata[CTRL_EN_BIT]     = (tmr_state_q == TMR_RUN);
                rdata[CTRL_RELOAD_BIT] = reload_q;
            end
            OFF_PERIOD: rdata = period_q;
            OFF_COUNT:  rdata = count_q;
            OFF_MASK:   rdata = {8'h00, mask_q};
            OFF_PEND:   rdata = {8'h00, pend_q};
            default:    rdata = '0;
        endcase
    end

    // Timer step/expiry decode. A CPU write to COUNT in the same cycle
    // overrides the step entirely, so it also suppresses any expiry.
    always_comb begin
        running = (tmr_state_q == TMR_RUN);
        step    = running && (presc_q == PRESC_LAST);
        at_end  = (count_q <= 16'd1);
        expire  = step && at_end && !wr.count;
    end

    // Prescaler: counts only while running, restarts on every step and
    // whenever software reloads COUNT so the next step is a full interval.
    always_comb begin
        presc_d = presc_q;
        if (!running || wr.count || step) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + 16'd1;
        end
    end

    // Counter and FSM next state. On expiry the counter either reloads from
    // PERIOD (periodic mode) or parks at zero and the FSM drops back to IDLE;
    // it never wraps below zero. A CTRL write lands last so software always
    // wins over the automatic EN clear in the same cycle.
    always_comb begin
        count_d     = count_q;
        tmr_state_d = tmr_state_q;
        reload_d    = reload_q;

        if (wr.count) begin
            count_d = wdata;
        end else if (step) begin
            if (at_end) begin
                count_d = reload_q ? period_q : 16'h0000;
            end else begin
                count_d = count_q - 16'd1;
            end
        end

        if (expire && !reload_q) begin
            tmr_state_d = TMR_IDLE;
        end

        if (wr.ctrl) begin
            tmr_state_d = wdata[CTRL_EN_BIT] ? TMR_RUN : TMR_IDLE;
            reload_d    = wdata[CTRL_RELOAD_BIT];
        end
    end

    // PERIOD and MASK are plain software registers.
    always_comb begin
        period_d = wr.period ? wdata : period_q;
        mask_d   = wr.mask ? wdata[7:0] : mask_q;
    end

    // Pending bits: clear what software wrote as ones, then OR in this
    // cycle's new events so a simultaneous set is never lost.
    always_comb begin
        logic [7:0] clr;
        logic [7:0] set;
        clr    = wr.pend ? wdata[7:0] : 8'h00;
        set    = {ext_rise, expire};
        pend_d = (pend_q & ~clr) | set;
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmr_state_q <= TMR_IDLE;
            reload_q    <= 1'b0;
            period_q    <= PERIOD_RESET;
            count_q     <= 16'h0000;
            presc_q     <= 16'h0000;
            mask_q      <= MASK_RESET;
            pend_q      <= 8'h00;
        end else begin
            tmr_state_q <= tmr_state_d;
            reload_q    <= reload_d;
            period_q    <= period_d;
            count_q     <= count_d;
            presc_q     <= presc_d;
            mask_q      <= mask_d;
            pend_q      <= pend_d;
        end
    end

endmodule

// File: tb/tb_io_irq_timer.sv
// Self-checking bench for io_irq_timer: directed scenarios plus randomized
// timer and external-interrupt traffic checked against expectations computed
// from the register-map rules (arrival times, sticky pending, masking).
module tb_io_irq_timer;

    localparam logic [15:0] BASE  = 16'hFF00;
    localparam logic [2:0]  O_CTRL   = 3'd0;
    localparam logic [2:0]  O_PERIOD = 3'd1;
    localparam logic [2:0]  O_COUNT  = 3'd2;
    localparam logic [2:0]  O_MASK   = 3'd3;
    localparam logic [2:0]  O_PEND   = 3'd4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] addresses = 16'h0000;
    logic        oe = 1'b0;
    logic [6:0]  ext_irq = 7'h00;
    logic [7:0]  int_e;
    wire  [15:0] data;

    logic        tb_drv_en = 1'b0;
    logic [15:0] tb_drv_val = 16'h0000;

    int errors = 0;
    int checks = 0;

    // CPU side of the shared bus; a pull-up makes a released bus read as FFFF.
    assign data = tb_drv_en ? tb_drv_val : 16'hzzzz;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_pull
            pullup pu (data[gi]);
        end
    endgenerate

    io_irq_timer #(
        .BASE     (BASE),
        .PRESCALE (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .addresses (addresses),
        .oe        (oe),
        .data      (data),
        .ext_irq   (ext_irq),
        .int_e     (int_e)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One CPU write cycle, captured at the next rising edge.
    task automatic bus_write(input logic [2:0] off, input logic [15:0] val);
        @(negedge clk);
        addresses  = BASE + 16'(off);
        oe         = 1'b1;
        tb_drv_en  = 1'b1;
        tb_drv_val = val;
        @(posedge clk);
        #1;
        oe        = 1'b0;
        tb_drv_en = 1'b0;
        addresses = 16'h0000;
        $display("wr off=%0d data=%h", off, val);
    endtask

    // Combinational CPU read inside the current cycle.
    task automatic bus_read(input logic [2:0] off, output logic [15:0] val);
        addresses = BASE + 16'(off);
        oe        = 1'b0;
        #1;
        val       = data;
        addresses = 16'h0000;
        $display("rd off=%0d data=%h", off, val);
    endtask

    task automatic test_reset();
        logic [15:0] v;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (int_e !== 8'h00) begin errors++; $display("FAIL reset_int_e: got %h want 00", int_e); end
        bus_read(O_CTRL, v);
        checks++; if (v !== 16'hFFFF) begin errors++; $display("FAIL reset_bus_released: got %h want FFFF", v); end
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        bus_read(O_CTRL, v);
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL reset_ctrl: got %h want 0000", v); end
        bus_read(O_PERIOD, v);
        checks++; if (v !== 16'hFFFF) begin errors++; $display("FAIL reset_period: got %h want FFFF", v); end
        bus_read(O_COUNT, v);
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL reset_count: got %h want 0000", v); end
        bus_read(O_MASK, v);
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL reset_mask: got %h want 0000", v); end
        bus_read(O_PEND, v);
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL reset_pend: got %h want 0000", v); end

        // Running periodic timer, then reset asserted in the middle of a cycle.
        bus_write(O_MASK, 16'h0001);
        bus_write(O_PERIOD, 16'h0001);
        bus_write(O_COUNT, 16'h0001);
        bus_write(O_CTRL, 16'h0003);
        repeat (2) @(posedge clk);
        #1;
        checks++; if (int_e !== 8'h01) begin errors++; $display("FAIL run_before_reset_int_e: got %h want 01", int_e); end
        bus_read(O_CTRL, v);
        checks++; if (v !== 16'h0003) begin errors++; $display("FAIL run_before_reset_ctrl: got %h want 0003", v); end
        #1;
        addresses = BASE;
        oe        = 1'b0;
        reset     = 1'b0;
        #1;
        checks++; if (int_e !== 8'h00) begin errors++; $display("FAIL midcycle_reset_int_e: got %h want 00", int_e); end
        checks++; if (data !== 16'hFFFF) begin errors++; $display("FAIL midcycle_reset_bus: got %h want FFFF", data); end
        addresses = 16'h0000;
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        bus_read(O_CTRL, v);
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL after_reset_ctrl: got %h want 0000", v); end
        bus_read(O_PERIOD, v);
        checks++; if (v !== 16'hFFFF) begin errors++; $display("FAIL after_reset_period: got %h want FFFF", v); end
        checks++; if (int_e !== 8'h00) begin errors++; $display("FAIL after_reset_int_e: got %h want 00", int_e); end
    endtask

    task automatic test_rw();
        logic [15:0] v;
        bus_write(O_PERIOD, 16'h0005);
        bus_write(O_MASK, 16'h0001);
        bus_write(3'd5, 16'h1234);
        bus_read(O_PERIOD, v);
        checks++; if (v !== 16'h0005) begin errors++; $display("FAIL rw_period: got %h want 0005", v); end
        bus_read(O_MASK, v);
        checks++; if (v !== 16'h0001) begin errors++; $display("FAIL rw_mask: got %h want 0001", v); end
        bus_read(3'd6, v);
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL rw_off6: got %h want 0000", v); end
        bus_read(3'd5, v);
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL rw_off5_ignored: got %h want 0000", v); end
        addresses = 16'hFE04; oe = 1'b0; #1;
        checks++; if (data !== 16'hFFFF) begin errors++; $display("FAIL rw_unselected_low: got %h want FFFF", data); end
        addresses = 16'hFF08; #1;
        checks++; if (data !== 16'hFFFF) begin errors++; $display("FAIL rw_unselected_high: got %h want FFFF", data); end
        addresses = 16'h0000;
    endtask

    task automatic test_oneshot();
        logic [15:0] v;
        bus_write(O_PEND, 16'h00FF);
        bus_write(O_COUNT, 16'h0003);
        bus_write(O_CTRL, 16'h0001);
        @(posedge clk); #1;
        bus_read(O_COUNT, v);
        checks++; if (v !== 16'h0002) begin errors++; $display("FAIL oneshot_count1: got %h want 0002", v); end
        @(posedge clk); #1;
        checks++; if (int_e !== 8'h00) begin errors++; $display("FAIL oneshot_early: got %h want 00", int_e); end
        @(posedge clk); #1;
        checks++; if (int_e !== 8'h01) begin errors++; $display("FAIL oneshot_fire: got %h want 01", int_e); end
        bus_read(O_CTRL, v);
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL oneshot_en_cleared: got %h want 0000", v); end
        bus_read(O_COUNT, v);
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL oneshot_count_end: got %h want 0000", v); end
        bus_write(O_PEND, 16'h0001);
        checks++; if (int_e !== 8'h00) begin errors++; $display("FAIL oneshot_w1c: got %h want 00", int_e); end
    endtask

    // Periodic timer with PEND W1C held every cycle: because a set wins over
    // a clear, int_e[0] after edge k is exactly "an expiry happened at k".
    // Expiries occur at k = max(c,1), then every max(p,1) edges.
    task automatic test_reload();
        int c;
        int p;
        logic exp_bit;
        c = 2; p = 2;
        bus_write(O_MASK, 16'h0001);
        bus_write(O_PEND, 16'h00FF);
        bus_write(O_PERIOD, 16'(p));
        bus_write(O_COUNT, 16'(c));
        bus_write(O_CTRL, 16'h0003);
        @(negedge clk);
        addresses = BASE + 16'(O_PEND); oe = 1'b1; tb_drv_en = 1'b1; tb_drv_val = 16'h0001;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            exp_bit = (k >= c) && (((k - c) % p) == 0);
            checks++;
            if (int_e[0] !== exp_bit) begin
                errors++; $display("FAIL reload_k%0d: got %b want %b", k, int_e[0], exp_bit);
            end
        end
        oe = 1'b0; tb_drv_en = 1'b0; addresses = 16'h0000;
        bus_write(O_CTRL, 16'h0000);
        bus_write(O_PEND, 16'h00FF);
    endtask

    task automatic test_timer_random();
        int c;
        int p;
        int first;
        int pmod;
        logic exp_bit;
        for (int t = 0; t < 4; t++) begin
            c = int'($urandom_range(0, 6));
            p = int'($urandom_range(0, 4));
            first = (c == 0) ? 1 : c;
            pmod  = (p == 0) ? 1 : p;
            $display("timer trial %0d: count=%0d period=%0d", t, c, p);
            bus_write(O_PERIOD, 16'(p));
            bus_write(O_COUNT, 16'(c));
            bus_write(O_CTRL, 16'h0003);
            @(negedge clk);
            addresses = BASE + 16'(O_PEND); oe = 1'b1; tb_drv_en = 1'b1; tb_drv_val = 16'h0001;
            for (int k = 1; k <= 12; k++) begin
                @(posedge clk); #1;
                exp_bit = (k >= first) && (((k - first) % pmod) == 0);
                checks++;
                if (int_e[0] !== exp_bit) begin
                    errors++; $display("FAIL timer_rand_t%0d_k%0d: got %b want %b", t, k, int_e[0], exp_bit);
                end
            end
            oe = 1'b0; tb_drv_en = 1'b0; addresses = 16'h0000;
            bus_write(O_CTRL, 16'h0000);
            bus_write(O_PEND, 16'h00FF);
        end
    endtask

    task automatic test_collision();
        logic [15:0] v;
        bus_write(O_MASK, 16'h0001);
        bus_write(O_PEND, 16'h00FF);
        bus_write(O_COUNT, 16'h0003);
        bus_write(O_CTRL, 16'h0001);
        repeat (2) @(posedge clk);
        #1;
        bus_read(O_COUNT, v);
        checks++; if (v !== 16'h0001) begin errors++; $display("FAIL collision_setup: got %h want 0001", v); end
        bus_write(O_COUNT, 16'd10);
        bus_read(O_COUNT, v);
        checks++; if (v !== 16'd10) begin errors++; $display("FAIL collision_count10: got %h want 000a", v); end
        checks++; if (int_e !== 8'h00) begin errors++; $display("FAIL collision_no_expiry: got %h want 00", int_e); end
        @(posedge clk); #1;
        bus_read(O_COUNT, v);
        checks++; if (v !== 16'd9) begin errors++; $display("FAIL collision_count9: got %h want 0009", v); end
        bus_write(O_CTRL, 16'h0000);
        bus_write(O_PEND, 16'h00FF);
    endtask

    task automatic test_ext();
        logic [15:0] v;
        bus_write(O_MASK, 16'h0000);
        @(negedge clk) ext_irq[2] = 1'b1;
        @(negedge clk) ext_irq[2] = 1'b0;
        @(posedge clk); #1;
        bus_read(O_PEND, v);
        checks++; if (v !== 16'h0000) begin errors++; $display("FAIL ext_latency_early: got %h want 0000", v); end
        @(posedge clk); #1;
        bus_read(O_PEND, v);
        checks++; if (v !== 16'h0008) begin errors++; $display("FAIL ext_pend: got %h want 0008", v); end
        checks++; if (int_e !== 8'h00) begin errors++; $display("FAIL ext_masked: got %h want 00", int_e); end
        bus_write(O_MASK, 16'h0008);
        checks++; if (int_e !== 8'h08) begin errors++; $display("FAIL ext_unmask: got %h want 08", int_e); end
        bus_write(O_PEND, 16'h0008);
        checks++; if (int_e !== 8'h00) begin errors++; $display("FAIL ext_w1c: got %h want 00", int_e); end
    endtask

    // Random external line activity with random MASK/PEND traffic. A line
    // value applied before edge j-2 that was low before edge j-3 sets its
    // pending bit at edge j; W1C clears first, new sets win.
    task automatic test_ext_random();
        logic [6:0]  hist[$];
        logic [7:0]  exp_pend;
        logic [7:0]  exp_mask;
        logic [7:0]  clr;
        logic [6:0]  set;
        logic [15:0] rnd;
        int          op;
        int          n;
        exp_mask = 8'($urandom);
        bus_write(O_CTRL, 16'h0000);
        bus_write(O_PEND, 16'h00FF);
        bus_write(O_MASK, {8'h00, exp_mask});
        exp_pend = 8'h00;
        hist.delete();
        repeat (3) hist.push_back(7'h00);
        for (int cyc = 0; cyc < 80; cyc++) begin
            @(negedge clk);
            op  = int'($urandom_range(0, 3));
            rnd = 16'($urandom);
            ext_irq = ext_irq ^ (7'($urandom) & 7'($urandom));
            clr = 8'h00;
            case (op)
                1: begin
                    addresses = BASE + 16'(O_PEND); oe = 1'b1; tb_drv_en = 1'b1; tb_drv_val = rnd;
                    clr = rnd[7:0];
                end
                2: begin
                    addresses = BASE + 16'(O_MASK); oe = 1'b1; tb_drv_en = 1'b1; tb_drv_val = rnd;
                end
                3: begin
                    addresses = BASE + 16'(O_PEND); oe = 1'b0;
                    #1;
                    checks++;
                    if (data !== {8'h00, exp_pend}) begin
                        errors++; $display("FAIL ext_rand_pend_c%0d: got %h want %h", cyc, data, {8'h00, exp_pend});
                    end
                end
                default: ;
            endcase
            $display("ext cycle %0d op=%0d ext=%h bus=%h", cyc, op, ext_irq, rnd);
            @(posedge clk);
            hist.push_back(ext_irq);
            n   = hist.size();
            set = hist[n-3] & ~hist[n-4];
            exp_pend = (exp_pend & ~clr) | {set, 1'b0};
            if (op == 2) exp_mask = rnd[7:0];
            #1;
            oe = 1'b0; tb_drv_en = 1'b0; addresses = 16'h0000;
            checks++;
            if (int_e !== (exp_pend & exp_mask)) begin
                errors++; $display("FAIL ext_rand_int_e_c%0d: got %h want %h", cyc, int_e, exp_pend & exp_mask);
            end
        end
        ext_irq = 7'h00;
        repeat (4) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_rw();
        test_oneshot();
        test_reload();
        test_timer_random();
        test_collision();
        test_ext();
        test_ext_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
